// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared types and constants for the reaction timer
package reaction_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GO   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // All-9s BCD pattern for up to 16 digits; callers keep the low 4*digits bits.
    function automatic logic [63:0] bcd_nines(input int digits);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < digits) v[4*i +: 4] = 4'h9;
        end
        return v;
    endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// rtl/bcd_sat_counter.sv - multi-digit BCD up-counter that sticks at all 9s
module bcd_sat_counter
    import reaction_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                enable,
    output logic [4*DIGITS-1:0] count,
    output logic                sat
);

    localparam logic [63:0]         NINES_W = bcd_nines(DIGITS);
    localparam logic [4*DIGITS-1:0] NINES   = NINES_W[4*DIGITS-1:0];

    logic [4*DIGITS-1:0] cnt_q;
    logic [4*DIGITS-1:0] cnt_inc;
    logic                carry;

    // Ripple carry: a digit wraps 9->0 and passes the carry upward.
    always_comb begin
        cnt_inc = cnt_q;
        carry   = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (cnt_q[4*d +: 4] == 4'd9) begin
                    cnt_inc[4*d +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*d +: 4] = cnt_q[4*d +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    assign sat   = (cnt_q == NINES);
    assign count = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !sat) begin
            cnt_q <= cnt_inc;
        end
    end

endmodule

// File: rtl/multi_reaction_timer.sv
// rtl/multi_reaction_timer.sv - N-player reaction timer with false-start and winner logic
module multi_reaction_timer
    import reaction_pkg::*;
#(
    parameter int                N_PLAYERS    = 2,
    parameter int                DIGITS       = 5,
    parameter int                TICK_DIV     = 10000,
    parameter int                LFSR_W       = 15,
    parameter logic [LFSR_W-1:0] LFSR_TAPS    = 15'h6000,
    parameter int                DELAY_MIN_MS = 1000,
    parameter int                DELAY_MASK   = 2047
) (
    input  logic                                         ADC_CLK_10,
    input  logic                                         RESET_N,
    input  logic                                         start,
    input  logic [N_PLAYERS-1:0]                         hit,
    output logic                                         go,
    output logic [STATE_W-1:0]                           state,
    output logic [N_PLAYERS*4*DIGITS-1:0]                result,
    output logic [N_PLAYERS-1:0]                         done,
    output logic [N_PLAYERS-1:0]                         false_start,
    output logic [((N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1)-1:0] winner,
    output logic                                         winner_valid
);

    localparam int RW    = 4 * DIGITS;
    localparam int WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam int DLY_W = $clog2(DELAY_MIN_MS + DELAY_MASK + 1);
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [63:0]   NINES_W = bcd_nines(DIGITS);
    localparam logic [RW-1:0] NINES   = NINES_W[RW-1:0];

    state_t                    state_q, state_d;
    logic [LFSR_W-1:0]         lfsr_q;
    logic [PS_W-1:0]           presc_q;
    logic [DLY_W-1:0]          delay_q;
    logic [N_PLAYERS*RW-1:0]   result_q;
    logic [N_PLAYERS-1:0]      done_q;
    logic [N_PLAYERS-1:0]      fs_q;
    logic [WIN_W-1:0]          winner_q;
    logic                      winner_valid_q;

    logic                      tick;
    logic                      arm;
    logic                      go_entry;
    logic [RW-1:0]             ms_count;
    logic                      ms_sat;
    logic [N_PLAYERS-1:0]      valid_hit;
    logic [WIN_W-1:0]          first_idx;
    logic [DLY_W-1:0]          delay_load;

    assign tick       = (presc_q == PS_W'(TICK_DIV - 1));
    assign arm        = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign go_entry   = (state_q == ST_WAIT) && (state_d == ST_GO);
    assign valid_hit  = hit & ~done_q;
    assign delay_load = DLY_W'(DELAY_MIN_MS) + DLY_W'(lfsr_q & LFSR_W'(DELAY_MASK));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_WAIT;
            ST_WAIT: begin
                if (&done_q)                     state_d = ST_DONE;
                else if (tick && delay_q <= 1)   state_d = ST_GO;
            end
            ST_GO:   if ((&done_q) || ms_sat) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_WAIT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Lowest index wins when several players hit on the same edge.
    always_comb begin
        first_idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (valid_hit[i]) first_idx = WIN_W'(i);
        end
    end

    always_ff @(posedge ADC_CLK_10 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_W'(1);
            presc_q <= '0;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
            if (arm || go_entry || tick) presc_q <= '0;
            else                         presc_q <= presc_q + PS_W'(1);
            if (arm)                                           delay_q <= delay_load;
            else if (state_q == ST_WAIT && tick && delay_q != 0) delay_q <= delay_q - DLY_W'(1);
        end
    end

    bcd_sat_counter #(
        .DIGITS (DIGITS)
    ) u_ms_counter (
        .clk    (ADC_CLK_10),
        .rst_n  (RESET_N),
        .clear  (arm || go_entry),
        .enable ((state_q == ST_GO) && tick),
        .count  (ms_count),
        .sat    (ms_sat)
    );

    always_ff @(posedge ADC_CLK_10 or negedge RESET_N) begin
        if (!RESET_N) begin
            result_q       <= '0;
            done_q         <= '0;
            fs_q           <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
        end else if (arm) begin
            result_q       <= '0;
            done_q         <= '0;
            fs_q           <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (hit[i]) begin
                            fs_q[i]              <= 1'b1;
                            done_q[i]            <= 1'b1;
                            result_q[i*RW +: RW] <= NINES;
                        end
                    end
                end
                ST_GO: begin
                    // On saturation ms_count already holds all 9s, so laggards get full scale.
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (!done_q[i] && (hit[i] || ms_sat)) begin
                            done_q[i]            <= 1'b1;
                            result_q[i*RW +: RW] <= ms_count;
                        end
                    end
                    if (!winner_valid_q && (|valid_hit)) begin
                        winner_q       <= first_idx;
                        winner_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign go           = (state_q == ST_GO);
    assign state        = state_q;
    assign result       = result_q;
    assign done         = done_q;
    assign false_start  = fs_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_multi_reaction_timer.sv
// tb/tb_multi_reaction_timer.sv - scoreboard bench for multi_reaction_timer
module tb_multi_reaction_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0;
    logic [1:0]  hit_a = 2'b00;
    logic        go_a;
    logic [1:0]  st_a;
    logic [15:0] res_a;
    logic [1:0]  done_a, fs_a;
    logic        win_a, wv_a;

    multi_reaction_timer #(
        .N_PLAYERS(2), .DIGITS(2), .TICK_DIV(4), .LFSR_W(15), .LFSR_TAPS(15'h6000),
        .DELAY_MIN_MS(3), .DELAY_MASK(0)
    ) dut_a (
        .ADC_CLK_10(clk), .RESET_N(rst_n), .start(start_a), .hit(hit_a),
        .go(go_a), .state(st_a), .result(res_a), .done(done_a),
        .false_start(fs_a), .winner(win_a), .winner_valid(wv_a)
    );

    logic        start_b = 1'b0;
    logic [2:0]  hit_b = 3'b000;
    logic        go_b;
    logic [1:0]  st_b;
    logic [35:0] res_b;
    logic [2:0]  done_b, fs_b;
    logic [1:0]  win_b;
    logic        wv_b;

    multi_reaction_timer #(
        .N_PLAYERS(3), .DIGITS(3), .TICK_DIV(2), .LFSR_W(15), .LFSR_TAPS(15'h6000),
        .DELAY_MIN_MS(3), .DELAY_MASK(2047)
    ) dut_b (
        .ADC_CLK_10(clk), .RESET_N(rst_n), .start(start_b), .hit(hit_b),
        .go(go_b), .state(st_b), .result(res_b), .done(done_b),
        .false_start(fs_b), .winner(win_b), .winner_valid(wv_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          kind;   // 0 = GO rise, 1 = round finished
        int          lat;
        logic [15:0] res;
        logic [1:0]  fs;
        logic        win;
        logic        wv;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic push_go(input int lat);
        exp_t x;
        x.kind = 0; x.lat = lat; x.res = '0; x.fs = '0; x.win = 1'b0; x.wv = 1'b0;
        sb.push_back(x);
    endtask

    task automatic push_done(input logic [15:0] res, input logic [1:0] fs,
                             input logic win, input logic wv);
        exp_t x;
        x.kind = 1; x.lat = 0; x.res = res; x.fs = fs; x.win = win; x.wv = wv;
        sb.push_back(x);
    endtask

    logic [1:0] prev_state = 2'd0;
    logic       prev_go = 1'b0;
    int         arm_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_state = 2'd0;
            prev_go    = 1'b0;
            arm_cnt    = 0;
        end else begin
            if (st_a == 2'd1 && prev_state != 2'd1) arm_cnt = 0;
            else                                    arm_cnt++;
            if (go_a && !prev_go) begin
                if (sb.size() == 0) chk("sb_underflow_go", 0, 1);
                else begin
                    e = sb.pop_front();
                    chk("go_event_kind", e.kind, 0);
                    chk("go_latency", arm_cnt, e.lat);
                end
            end
            if (st_a == 2'd3 && prev_state != 2'd3) begin
                if (sb.size() == 0) chk("sb_underflow_done", 0, 1);
                else begin
                    e = sb.pop_front();
                    chk("done_event_kind", e.kind, 1);
                    chk("round_result", res_a, e.res);
                    chk("round_done", done_a, 2'b11);
                    chk("round_false_start", fs_a, e.fs);
                    chk("round_winner_valid", wv_a, e.wv);
                    chk("round_winner", win_a, e.win);
                end
            end
            prev_state = st_a;
            prev_go    = go_a;
        end
    end

    task automatic pulse_start(input bit which_b);
        @(negedge clk);
        if (which_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Hit is sampled on the n-th rising edge after the current negedge.
    task automatic pulse_hit(input logic [1:0] mask, input int n);
        repeat (n - 1) @(negedge clk);
        hit_a = mask;
        @(negedge clk);
        hit_a = 2'b00;
    endtask

    task automatic wait_go_a();
        int k = 0;
        while (!go_a && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!go_a) chk("go_timeout", 0, 1);
    endtask

    task automatic wait_done_a(input int bound);
        int k = 0;
        while (st_a != 2'd3 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (st_a != 2'd3) chk("done_timeout", st_a, 3);
    endtask

    task automatic b_round(output int lat);
        int k = 0;
        pulse_start(1'b1);
        lat = 0;
        while (!go_b && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        chk("b_go_seen", go_b, 1);
        chk("b_delay_in_range", (lat >= 6 && lat <= 4100), 1);
        while (st_b != 2'd3 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("b_sat_state", st_b, 3);
        chk("b_sat_result", res_b, {3{12'h999}});
        chk("b_sat_winner_valid", wv_b, 0);
    endtask

    int lat1, lat2;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", st_a, 0);
        chk("reset_go", go_a, 0);
        chk("reset_result", res_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_winner_valid", wv_a, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round 1: normal play, player 0 first at 5 ms, player 1 at 7 ms.
        push_go(12);
        push_done({8'h07, 8'h05}, 2'b00, 1'b0, 1'b1);
        pulse_start(1'b0);
        wait_go_a();
        pulse_hit(2'b01, 22);
        pulse_hit(2'b10, 8);
        wait_done_a(50);

        // Round 2 from DONE: player 1 false-starts, player 0 hits at 5 ms.
        push_go(12);
        push_done({8'h99, 8'h05}, 2'b10, 1'b0, 1'b1);
        pulse_start(1'b0);
        pulse_hit(2'b10, 2);
        wait_go_a();
        pulse_hit(2'b01, 22);
        wait_done_a(50);

        // Round 3: simultaneous hits at 2 ms.
        push_go(12);
        push_done({8'h02, 8'h02}, 2'b00, 1'b0, 1'b1);
        pulse_start(1'b0);
        wait_go_a();
        pulse_hit(2'b11, 10);
        wait_done_a(50);

        // Round 4: nobody hits, count saturates at 99.
        push_go(12);
        push_done({8'h99, 8'h99}, 2'b00, 1'b0, 1'b0);
        pulse_start(1'b0);
        wait_go_a();
        wait_done_a(1000);

        // Round 5: both players false-start, no GO.
        push_done({8'h99, 8'h99}, 2'b11, 1'b0, 1'b0);
        pulse_start(1'b0);
        pulse_hit(2'b11, 3);
        wait_done_a(50);

        // Round 6: player 1 wins at 1 ms, player 0 at 2 ms.
        push_go(12);
        push_done({8'h01, 8'h02}, 2'b00, 1'b1, 1'b1);
        pulse_start(1'b0);
        wait_go_a();
        pulse_hit(2'b10, 5);
        pulse_hit(2'b01, 4);
        wait_done_a(50);

        // Round 7: start ignored mid-GO, then asynchronous reset.
        push_go(12);
        pulse_start(1'b0);
        wait_go_a();
        repeat (5) @(negedge clk);
        pulse_start(1'b0);
        chk("start_in_go_ignored", st_a, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_go", go_a, 0);
        chk("async_reset_state", st_a, 0);
        chk("async_reset_result", res_a, 0);
        chk("async_reset_done", done_a, 0);
        chk("async_reset_winner", {wv_a, win_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Wide random delay: two successive rounds draw different delays.
        b_round(lat1);
        b_round(lat2);
        chk("b_delays_differ", (lat1 != lat2), 1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_reaction_timer.md
# multi_reaction_timer

Parametrised N-player reaction-time engine: arms on a start pulse, waits a pseudo-random delay, raises a GO lamp, then times each player's hit in milliseconds as a saturating BCD count. Successor to the single-player counter/LFSR/control chain in the DE10-Lite top level. Adds configurable player count, digit count and delay range, plus false-start detection, timeout and winner arbitration. Sits between the debounced KEY/SW inputs and the seven-segment/LED display logic.

## Interface
- `N_PLAYERS`, 2: number of independent hit inputs (1..8).
- `DIGITS`, 5: BCD digits per result; full scale 10^DIGITS−1 ms.
- `TICK_DIV`, 10000: clock cycles per ms tick (10 MHz → 1 ms).
- `LFSR_W`, 15: random-source width.
- `LFSR_TAPS`, 15'h6000: Fibonacci feedback mask (x^15+x^14+1).
- `DELAY_MIN_MS`, 1000: minimum pre-GO delay.
- `DELAY_MASK`, 2047: random part = LFSR & DELAY_MASK ms.
- `ADC_CLK_10` in 1: sole clock, all logic on rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle synchronous pulse, arms a round.
- `hit` in N_PLAYERS: single-cycle synchronous pulses, one per player.
- `go` out 1: GO lamp, high only in state GO.
- `state` out 2: IDLE=0, WAIT=1, GO=2, DONE=3.
- `result` out N_PLAYERS*4*DIGITS: per-player BCD time; player i at bits [i*4*DIGITS +: 4*DIGITS].
- `done` out N_PLAYERS: player result final.
- `false_start` out N_PLAYERS: player hit during WAIT.
- `winner` out $clog2(N_PLAYERS) (min 1): index of first valid hitter.
- `winner_valid` out 1: winner field meaningful.

## Operation
- Reset: state IDLE, go=0, all result/done/false_start/winner/winner_valid = 0, prescaler/delay/ms counters 0, LFSR = 1.
- LFSR free-runs every cycle from reset, never zero.
- IDLE: start → WAIT; on same edge clear result/done/false_start/winner_valid, load delay = DELAY_MIN_MS + (LFSR & DELAY_MASK), clear prescaler.
- WAIT: each tick decrements delay. hit[i] → false_start[i]=1, done[i]=1, result[i]=all 9s. Delay reaching 0 on a tick → GO, clear prescaler and ms count. If all players false-start → DONE, winner_valid=0.
- GO: ms count (BCD, ripple-carry per digit) increments each tick, saturates at all 9s. hit[i] with done[i]=0 → result[i]=current count, done[i]=1. First such hit sets winner/winner_valid; simultaneous first hits → lowest index wins. Hits from done players ignored.
- GO exit → DONE when all done=1, or count saturated (remaining players: result all 9s, done=1).
- DONE: results held. start → WAIT (new round, same clearing as from IDLE).
- start in WAIT/GO ignored. hit in IDLE/DONE ignored.
- Tick: prescaler counts 0..TICK_DIV−1, tick on the cycle it equals TICK_DIV−1, then wraps.
- Delay counter width = $clog2(DELAY_MIN_MS+DELAY_MASK+1).
- Reset mid-round: immediate return to reset values, no residual outputs.

## Timing
- start at edge k → state=WAIT, cleared outputs visible after edge k.
- WAIT→GO exactly (DELAY_MIN_MS + rnd)·TICK_DIV cycles after the arming edge; go high same cycle state=GO.
- Hit sampled at edge k → result/done/winner visible after edge k, value = count register before that edge's increment (hit coinciding with tick records the pre-tick value).
- Result = number of complete ticks between GO entry and hit; hit within first TICK_DIV cycles → 0.
- DONE entry one edge after the last done bit or saturation.

## Structure
- Package `reaction_pkg`: state enum (IDLE/WAIT/GO/DONE), state width constant, all-9s BCD constant function of DIGITS.
- Sub-module `bcd_sat_counter` (DIGITS parameter; clear, enable, saturating output, sat flag) used for the ms count.
- LFSR, prescaler, FSM, per-player latch array in the top body.

## Test plan
- TICK_DIV=4, DELAY_MIN_MS=3, DELAY_MASK=0, N=2: start → go rises 12 cycles later; hit[0] 22 cycles after go → result0=BCD 5, winner=0, winner_valid=1.
- Same config: hit[1] 2 cycles into WAIT → false_start=2'b10, result1=99999, done1; hit[0] after go → DONE, winner=0.
- hit=2'b11 on same cycle in GO → both results equal, winner=0.
- DIGITS=2, no hits: count saturates at 99 → both results 99, done=2'b11, winner_valid=0, state DONE.
- RESET_N low mid-GO → go=0, state IDLE, all outputs 0 asynchronously; start mid-GO has no effect.
- DONE then start → WAIT with results/done/winner_valid cleared; two successive rounds draw different delays with DELAY_MASK=2047.
